knn_sequencer: RTL and testbench

KNN_SEQUENCER -- requirements
Module: knn_sequencer

---
 rtl/knn_sequencer.sv | 103 ++++++++++
 tb/tb_knn_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_sequencer.sv
// Control sequencer for a k-NN distance engine: loads the reference point, streams
// data points dimension by dimension and flags each finished distance to the sorter.
module knn_sequencer #(
  parameter int numberOfDimensions = 32,
  parameter int pipeLatency        = 2,
  parameter int pointCountWidth    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [pointCountWidth-1:0] numPoints,
  input  logic                       refValid,
  output logic                       refReady,
  output logic                       loadRef,
  input  logic                       dataValid,
  output logic                       dataReady,
  output logic                       accClear,
  output logic                       valid,
  output logic [pointCountWidth-1:0] pointName,
  output logic                       busy,
  output logic                       done
);

  localparam int DW = $clog2(numberOfDimensions);
  localparam int PW = pointCountWidth;

  typedef enum logic [2:0] {IDLE, LOAD_REF, STREAM, DRAIN, FINISH} state_t;

  state_t        state, nextState;
  logic [DW-1:0] dimCount;
  logic [PW-1:0] pointCount;
  logic [PW-1:0] numPointsReg;

  // Delay line aligns each point-end marker with its distance leaving the datapath.
  logic [pipeLatency-1:0] lineValid;
  logic [PW-1:0]          lineName [pipeLatency];

  logic refBeat, dataBeat, lastDim, pointEnd, lastPoint;

  always_comb begin
    nextState = state;
    refReady  = (state == LOAD_REF);
    dataReady = (state == STREAM);
    refBeat   = refValid & refReady;
    dataBeat  = dataValid & dataReady;
    lastDim   = (dimCount == DW'(numberOfDimensions - 1));
    pointEnd  = dataBeat & lastDim;
    lastPoint = (pointCount == numPointsReg - PW'(1));
    loadRef   = refBeat;
    accClear  = dataBeat & (dimCount == '0);
    busy      = (state != IDLE);
    done      = (state == FINISH);
    valid     = lineValid[pipeLatency-1];
    pointName = lineName[pipeLatency-1];

    unique case (state)
      IDLE: begin
        if (start) nextState = (numPoints != '0) ? LOAD_REF : FINISH;
      end
      LOAD_REF: begin
        if (refBeat && lastDim) nextState = STREAM;
      end
      STREAM: begin
        if (pointEnd && lastPoint) nextState = DRAIN;
      end
      DRAIN: begin
        if (lineValid == '0) nextState = FINISH;
      end
      FINISH: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dimCount     <= '0;
      pointCount   <= '0;
      numPointsReg <= '0;
      lineValid    <= '0;
      for (int unsigned i = 0; i < pipeLatency; i++) lineName[i] <= '0;
    end else begin
      state <= nextState;

      if (state == IDLE && start && numPoints != '0) begin
        numPointsReg <= numPoints;
        dimCount     <= '0;
        pointCount   <= '0;
      end

      if (refBeat || dataBeat) dimCount <= lastDim ? '0 : dimCount + DW'(1);
      if (pointEnd) pointCount <= pointCount + PW'(1);

      lineValid[0] <= pointEnd;
      lineName[0]  <= pointCount;
      for (int unsigned i = 1; i < pipeLatency; i++) begin
        lineValid[i] <= lineValid[i-1];
        lineName[i]  <= lineName[i-1];
      end
    end
  end

endmodule

// File: tb/tb_knn_sequencer.sv
// Self-checking bench for knn_sequencer: two instances (4-dim and 32-dim) driven with
// randomized handshakes and checked against a beat-level transaction model.
module tb_knn_sequencer;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset, startA, startB, refValid, dataValid;
  logic [PW-1:0] numPoints;

  logic aRefReady, aLoadRef, aDataReady, aAccClear, aValid, aBusy, aDone;
  logic bRefReady, bLoadRef, bDataReady, bAccClear, bValid, bBusy, bDone;
  logic [PW-1:0] aPointName, bPointName;

  logic oRefReady, oLoadRef, oDataReady, oAccClear, oValid, oBusy, oDone;
  logic [PW-1:0] oPointName;

  int sel, nDims, lat;
  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int name; } exp_t;
  exp_t expQ[$];

  always #5 clk = ~clk;

  knn_sequencer #(.numberOfDimensions(4), .pipeLatency(2), .pointCountWidth(PW)) dutA (
    .clk(clk), .reset(reset), .start(startA), .numPoints(numPoints),
    .refValid(refValid), .refReady(aRefReady), .loadRef(aLoadRef),
    .dataValid(dataValid), .dataReady(aDataReady), .accClear(aAccClear),
    .valid(aValid), .pointName(aPointName), .busy(aBusy), .done(aDone));

  knn_sequencer #(.numberOfDimensions(32), .pipeLatency(3), .pointCountWidth(PW)) dutB (
    .clk(clk), .reset(reset), .start(startB), .numPoints(numPoints),
    .refValid(refValid), .refReady(bRefReady), .loadRef(bLoadRef),
    .dataValid(dataValid), .dataReady(bDataReady), .accClear(bAccClear),
    .valid(bValid), .pointName(bPointName), .busy(bBusy), .done(bDone));

  always_comb begin
    if (sel == 0) begin
      {oRefReady, oLoadRef, oDataReady, oAccClear, oValid, oBusy, oDone} =
        {aRefReady, aLoadRef, aDataReady, aAccClear, aValid, aBusy, aDone};
      oPointName = aPointName;
    end else begin
      {oRefReady, oLoadRef, oDataReady, oAccClear, oValid, oBusy, oDone} =
        {bRefReady, bLoadRef, bDataReady, bAccClear, bValid, bBusy, bDone};
      oPointName = bPointName;
    end
  end

  task automatic setStart(input logic v);
    if (sel == 0) startA = v; else startB = v;
  endtask

  // One query: mode 0 continuous, 1 toggling, 2 random, 3 ref gap of 5 cycles mid-load.
  task automatic runQuery(input int np, input int mode, input bit extraStart, input int resetPoint);
    int cyc = 0, refBeats = 0, dataBeats = 0, valids = 0, dones = 0, busyCycles = 0;
    int gap = 0, lastValidCyc = -1, lastEndCyc = -1;
    bit resetPending = 0, finished = 0, expV, expAcc;
    exp_t e;
    expQ.delete();
    @(posedge clk); #1;
    setStart(1'b1); numPoints = PW'(np); refValid = 1'b0; dataValid = 1'b0;
    @(negedge clk);
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("FAIL idleBeforeStart busy=%b want 0", oBusy); end

    while (!finished && cyc < 3000) begin
      @(posedge clk); #1;
      setStart(1'b0);
      cyc++;
      if (extraStart && dataBeats == 1) begin setStart(1'b1); numPoints = PW'(np + 5); end
      case (mode)
        0: begin refValid = 1'b1; dataValid = 1'b1; end
        1: begin refValid = 1'b1; dataValid = cyc[0]; end
        2: begin refValid = 1'($urandom_range(0, 1)); dataValid = 1'($urandom_range(0, 1)); end
        default: begin
          refValid = !(refBeats >= 10 && gap < 5);
          if (refBeats >= 10 && gap < 5) gap++;
          dataValid = 1'b1;
        end
      endcase

      if (resetPending) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({oRefReady, oLoadRef, oDataReady, oAccClear, oValid, oBusy, oDone} !== 7'b0 || oPointName !== '0) begin
          errors++;
          $display("FAIL resetOutputs got=%b name=%0d want all 0",
                   {oRefReady, oLoadRef, oDataReady, oAccClear, oValid, oBusy, oDone}, oPointName);
        end
        for (int i = 0; i < 15; i++) begin
          @(posedge clk); #1;
          @(negedge clk);
          checks++;
          if (oValid || oDone || oBusy) begin
            errors++;
            $display("FAIL abandonedQuery valid=%b done=%b busy=%b want 0", oValid, oDone, oBusy);
          end
        end
        expQ.delete();
        return;
      end

      @(negedge clk);
      if (oBusy) busyCycles++;
      checks++;
      if (oRefReady && oDataReady) begin errors++; $display("FAIL readyExclusive ref=1 data=1 want not both"); end

      checks++;
      if (oRefReady) begin
        if (oLoadRef !== refValid) begin errors++; $display("FAIL loadRef got=%b want %b", oLoadRef, refValid); end
        if (oLoadRef) refBeats++;
      end else if (oLoadRef !== 1'b0) begin
        errors++; $display("FAIL loadRefIdle got=%b want 0", oLoadRef);
      end

      if (oDataReady) begin
        checks++;
        if (refBeats != nDims || dataBeats >= np * nDims) begin
          errors++; $display("FAIL dataPhase refBeats=%0d dataBeats=%0d want ref=%0d data<%0d",
                             refBeats, dataBeats, nDims, np * nDims);
        end
        expAcc = dataValid && (dataBeats % nDims == 0);
        checks++;
        if (oAccClear !== expAcc) begin errors++; $display("FAIL accClear beat=%0d got=%b want %b", dataBeats, oAccClear, expAcc); end
        if (dataValid) begin
          if (dataBeats % nDims == nDims - 1) begin
            expQ.push_back('{cyc + lat, dataBeats / nDims});
            lastEndCyc = cyc;
            if (dataBeats / nDims == resetPoint) resetPending = 1;
          end
          dataBeats++;
        end
      end else begin
        checks++;
        if (oAccClear !== 1'b0) begin errors++; $display("FAIL accClearIdle got=%b want 0", oAccClear); end
      end

      expV = (expQ.size() > 0) && (expQ[0].cyc == cyc);
      checks++;
      if (oValid !== expV) begin errors++; $display("FAIL valid cyc=%0d got=%b want %b", cyc, oValid, expV); end
      if (expV) begin
        e = expQ.pop_front();
        checks++;
        if (int'(oPointName) != e.name) begin errors++; $display("FAIL pointName got=%0d want %0d", oPointName, e.name); end
      end
      if (oValid) begin valids++; lastValidCyc = cyc; end

      if (oDone) begin
        dones++;
        finished = 1;
        checks++;
        if (oValid || expQ.size() != 0 || dataBeats != np * nDims || cyc <= lastValidCyc ||
            (np > 0 && cyc - lastEndCyc > lat + 3)) begin
          errors++;
          $display("FAIL doneTiming cyc=%0d lastValid=%0d lastEnd=%0d beats=%0d want after drain, beats=%0d",
                   cyc, lastValidCyc, lastEndCyc, dataBeats, np * nDims);
        end
      end
    end

    checks++;
    if (!finished) begin errors++; $display("FAIL timeout no done within %0d cycles", cyc); end
    @(posedge clk); #1;
    refValid = 1'b0; dataValid = 1'b0;
    @(negedge clk);
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin errors++; $display("FAIL afterDone busy=%b done=%b want 0 0", oBusy, oDone); end
    checks++;
    if (valids != np || dones != 1) begin errors++; $display("FAIL counts valids=%0d dones=%0d want %0d 1", valids, dones, np); end
    checks++;
    if (refBeats != ((np == 0) ? 0 : nDims)) begin errors++; $display("FAIL refBeats got=%0d want %0d", refBeats, (np == 0) ? 0 : nDims); end
    if (np == 0) begin
      checks++;
      if (busyCycles != 1) begin errors++; $display("FAIL zeroPointsBusy got=%0d want 1", busyCycles); end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; startA = 1'b1; startB = 1'b1; numPoints = 16'd3;
    @(posedge clk); #1;
    reset = 1'b0; startA = 1'b0; startB = 1'b0; refValid = 1'b1; dataValid = 1'b1;
    @(negedge clk);
    checks++;
    if ({aRefReady, aLoadRef, aDataReady, aAccClear, aValid, aBusy, aDone} !== 7'b0 || aPointName !== '0) begin
      errors++; $display("FAIL resetStateA got=%b want 0", {aRefReady, aLoadRef, aDataReady, aAccClear, aValid, aBusy, aDone});
    end
    checks++;
    if ({bRefReady, bLoadRef, bDataReady, bAccClear, bValid, bBusy, bDone} !== 7'b0 || bPointName !== '0) begin
      errors++; $display("FAIL resetStateB got=%b want 0", {bRefReady, bLoadRef, bDataReady, bAccClear, bValid, bBusy, bDone});
    end
  endtask

  task automatic test_basic();             runQuery(3, 0, 0, -1); endtask
  task automatic test_toggle();            runQuery(3, 1, 0, -1); endtask
  task automatic test_zero_points();       runQuery(0, 0, 0, -1); endtask
  task automatic test_start_in_stream();   runQuery(3, 0, 1, -1); endtask
  task automatic test_reset_mid_query();   runQuery(3, 0, 0, 1); runQuery(3, 0, 0, -1); endtask
  task automatic test_random();
    repeat (5) runQuery(int'($urandom_range(1, 6)), 2, 0, -1);
  endtask
  task automatic test_long_dims();
    sel = 1; nDims = 32; lat = 3;
    runQuery(1, 3, 0, -1);
    runQuery(2, 2, 0, -1);
  endtask

  initial begin
    sel = 0; nDims = 4; lat = 2;
    reset = 1'b1; startA = 1'b0; startB = 1'b0; refValid = 1'b0; dataValid = 1'b0; numPoints = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_toggle();
    test_zero_points();
    test_start_in_stream();
    test_reset_mid_query();
    test_random();
    test_long_dims();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
